// File: rtl/eep_ctrl.sv
// Bus master for the 4 x 14-bit EEPROM: single-cycle host requests become read cycles
// or write cycles followed by a counted charge-pump window. Optional readback verify: EEP_VERIFY_EN.
module eep_ctrl #(
   parameter int CP_CYCLES = 1500000,
   parameter int CNT_W     = 21
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_rd,
   input  logic        req_wrt,
   input  logic [1:0]  req_addr,
   input  logic [13:0] req_data,
   input  logic [13:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic [13:0] rd_out,
   output logic        wrt_err,
   output logic [1:0]  eep_addr,
   output logic [13:0] wrt_data,
   output logic        eep_cs_n,
   output logic        eep_r_w_n,
   output logic        chrg_pmp_en
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, READ, RD_CAP, WRITE, PUMP, VFY_RD, VFY_CAP} state_t;

   state_t            state, nxt;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              busy_d, done_d, cs_d, rw_d, pmp_d;
   logic [1:0]        addr_d;
   logic [13:0]       data_d, rd_d;
`ifdef EEP_VERIFY_EN
   logic              err_d;
`endif

   // Every output is a flop; this block only computes their next values.
   always_comb begin
      nxt    = state;
      cnt_d  = cnt;
      busy_d = busy;
      done_d = 1'b0;
      cs_d   = eep_cs_n;
      rw_d   = eep_r_w_n;
      pmp_d  = chrg_pmp_en;
      addr_d = eep_addr;
      data_d = wrt_data;
      rd_d   = rd_out;
`ifdef EEP_VERIFY_EN
      err_d  = wrt_err;
`endif
      case (state)
         IDLE: begin
            if (req_wrt) begin
               nxt    = WRITE;
               addr_d = req_addr;
               data_d = req_data;
               cs_d   = 1'b0;
               rw_d   = 1'b0;
               pmp_d  = 1'b1;
               busy_d = 1'b1;
            end else if (req_rd) begin
               nxt    = READ;
               addr_d = req_addr;
               cs_d   = 1'b0;
               rw_d   = 1'b1;
               busy_d = 1'b1;
            end
         end
         READ: begin
            nxt  = RD_CAP;
            cs_d = 1'b1;
            rd_d = rd_data;
         end
         RD_CAP: begin
            nxt    = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         WRITE: begin
            nxt   = PUMP;
            cs_d  = 1'b1;
            rw_d  = 1'b1;
            cnt_d = '0;
         end
         PUMP: begin
            // Pump drops first; the state leaves PUMP one clock later.
            if (!chrg_pmp_en) begin
`ifdef EEP_VERIFY_EN
               nxt  = VFY_RD;
               cs_d = 1'b0;
               rw_d = 1'b1;
`else
               nxt    = IDLE;
               busy_d = 1'b0;
               done_d = 1'b1;
`endif
            end else if (cnt == CNT_LAST) begin
               pmp_d = 1'b0;
               cnt_d = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
`ifdef EEP_VERIFY_EN
         VFY_RD: begin
            nxt   = VFY_CAP;
            cs_d  = 1'b1;
            err_d = (rd_data != wrt_data);
         end
         VFY_CAP: begin
            nxt    = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
`endif
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         eep_cs_n    <= 1'b1;
         eep_r_w_n   <= 1'b1;
         chrg_pmp_en <= 1'b0;
         eep_addr    <= '0;
         wrt_data    <= '0;
         rd_out      <= '0;
      end else begin
         state       <= nxt;
         cnt         <= cnt_d;
         busy        <= busy_d;
         done        <= done_d;
         eep_cs_n    <= cs_d;
         eep_r_w_n   <= rw_d;
         chrg_pmp_en <= pmp_d;
         eep_addr    <= addr_d;
         wrt_data    <= data_d;
         rd_out      <= rd_d;
      end
   end

`ifdef EEP_VERIFY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wrt_err <= 1'b0;
      else        wrt_err <= err_d;
   end
`else
   assign wrt_err = 1'b0;
`endif

endmodule

// File: tb/tb_eep_ctrl.sv
// Directed bench for eep_ctrl with a behavioural EEPROM (read latch, write commit,
// pump-length check) and a read-data scoreboard queue.
module tb_eep_ctrl;

   localparam int CP    = 20;
   localparam int CNT_W = 5;
`ifdef EEP_VERIFY_EN
   localparam int WR_BUSY = CP + 4;
   localparam int WR_CSL  = 1;
`else
   localparam int WR_BUSY = CP + 2;
   localparam int WR_CSL  = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, req_rd, req_wrt;
   logic [1:0]  req_addr;
   logic [13:0] req_data, rd_data;
   logic        busy, done, wrt_err, eep_cs_n, eep_r_w_n, chrg_pmp_en;
   logic [13:0] rd_out, wrt_data;
   logic [1:0]  eep_addr;

   int checks = 0;
   int errors = 0;
   logic [13:0] exp_q[$];

   eep_ctrl #(.CP_CYCLES(CP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wrt(req_wrt),
      .req_addr(req_addr), .req_data(req_data), .rd_data(rd_data),
      .busy(busy), .done(done), .rd_out(rd_out), .wrt_err(wrt_err),
      .eep_addr(eep_addr), .wrt_data(wrt_data), .eep_cs_n(eep_cs_n),
      .eep_r_w_n(eep_r_w_n), .chrg_pmp_en(chrg_pmp_en)
   );

   always #5 clk = ~clk;

   // EEPROM model: contents survive controller reset
   logic [13:0] mem [4];
   bit          inited, pend, pump_err, corrupt;
   int          pcnt;
   logic [1:0]  paddr;

   always @(negedge clk)
      if (!eep_cs_n && eep_r_w_n) rd_data <= mem[eep_addr];

   always @(posedge clk) begin
      if (!inited) begin
         mem[0] <= 14'h0001; mem[1] <= 14'h0002; mem[2] <= 14'h0003; mem[3] <= 14'h0004;
         inited <= 1'b1;
      end else if (!eep_cs_n && !eep_r_w_n) begin
         mem[eep_addr] <= wrt_data;
         pend  <= 1'b1;
         pcnt  <= 1;
         paddr <= eep_addr;
      end else begin
         if (corrupt) mem[0] <= 14'h0000;
         if (pend) begin
            if (chrg_pmp_en) pcnt <= pcnt + 1;
            else begin
               pend <= 1'b0;
               if (pcnt < CP + 1) begin
                  pump_err    <= 1'b1;
                  mem[paddr]  <= 14'h3FFF;
               end
            end
         end
      end
   end

   // Pump pulse length monitor
   int run = 0, plen = 0;
   always @(posedge clk) begin
      if (chrg_pmp_en) run <= run + 1;
      else if (run != 0) begin
         plen <= run;
         run  <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Present a request for one clock; returns at the negedge after acceptance.
   task automatic do_req(input logic wr, input logic rd, input logic [1:0] a, input logic [13:0] d);
      req_wrt = wr; req_rd = rd; req_addr = a; req_data = d;
      @(negedge clk);
      req_wrt = 1'b0; req_rd = 1'b0;
   endtask

   // Wait for done; counts busy clocks, extra cs_n-low clocks and busy dropouts.
   task automatic run_op(input string tag, input bit inj, input bit cor,
                         output int cyc, output int csl, output int nbusy);
      cyc = 0; csl = 0; nbusy = 0;
      while (!done && cyc < 200) begin
         if (cyc > 0 && !eep_cs_n) csl++;
         if (!busy) nbusy++;
         req_rd  = (cyc == 5) ? inj : 1'b0;
         corrupt = (cyc == 5) ? cor : 1'b0;
         @(negedge clk);
         cyc++;
      end
      req_rd = 1'b0; corrupt = 1'b0;
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_busy_lo_at_done"}, busy, 1'b0);
   endtask

   task automatic rd_op(input string tag, input logic [1:0] a, input logic [13:0] expv);
      int cyc, csl, nb;
      exp_q.push_back(expv);
      do_req(1'b0, 1'b1, a, 14'h0);
      check({tag, "_cs_lo"}, eep_cs_n, 1'b0);
      check({tag, "_rw_hi"}, eep_r_w_n, 1'b1);
      run_op(tag, 1'b0, 1'b0, cyc, csl, nb);
      check({tag, "_latency"}, cyc, 2);
      check({tag, "_data"}, rd_out, exp_q.pop_front());
   endtask

   task automatic wr_op(input string tag, input logic rd_too, input logic [1:0] a,
                        input logic [13:0] d, input bit inj, input bit cor, input logic experr);
      int cyc, csl, nb;
      do_req(1'b1, rd_too, a, d);
      check({tag, "_rw_lo"}, eep_r_w_n, 1'b0);
      check({tag, "_pump_on"}, chrg_pmp_en, 1'b1);
      run_op(tag, inj, cor, cyc, csl, nb);
      check({tag, "_busy_clks"}, cyc, WR_BUSY);
      check({tag, "_extra_cs"}, csl, WR_CSL);
      check({tag, "_busy_drop"}, nb, 0);
      check({tag, "_pump_len"}, plen, CP + 1);
      check({tag, "_wrt_err"}, wrt_err, experr);
      check({tag, "_addr_hold"}, eep_addr, a);
      check({tag, "_data_hold"}, wrt_data, d);
   endtask

   initial begin
      rst_n = 1'b0; req_rd = 1'b0; req_wrt = 1'b0; req_addr = '0; req_data = '0; corrupt = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rd_out", rd_out, 14'h0);
      check("rst_wrt_err", wrt_err, 1'b0);
      check("rst_cs_n", eep_cs_n, 1'b1);
      check("rst_r_w_n", eep_r_w_n, 1'b1);
      check("rst_pump", chrg_pmp_en, 1'b0);
      check("rst_addr", eep_addr, 2'd0);
      check("rst_wdata", wrt_data, 14'h0);
      rst_n = 1'b1;
      @(negedge clk);

      rd_op("rd2", 2'd2, 14'h0003);
      wr_op("wr1", 1'b0, 2'd1, 14'h2A5C, 1'b1, 1'b0, 1'b0);
      check("wr1_no_eep_err", pump_err, 1'b0);
      rd_op("rd1", 2'd1, 14'h2A5C);
      wr_op("wr3_both", 1'b1, 2'd3, 14'h1111, 1'b0, 1'b0, 1'b0);
      rd_op("rd3", 2'd3, 14'h1111);
      rd_op("rd0", 2'd0, 14'h0001);
`ifdef EEP_VERIFY_EN
      wr_op("vfy_ok", 1'b0, 2'd0, 14'h0F0F, 1'b0, 1'b0, 1'b0);
      wr_op("vfy_bad", 1'b0, 2'd0, 14'h0F0F, 1'b0, 1'b1, 1'b1);
      check("vfy_rd_out_kept", rd_out, 14'h0001);
`endif
      check("pre_rst_no_eep_err", pump_err, 1'b0);

      // Reset in the middle of the pump window
      do_req(1'b1, 1'b0, 2'd2, 14'h0AAA);
      repeat (10) @(negedge clk);
      check("mid_pump_on", chrg_pmp_en, 1'b1);
      check("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("arst_pump_off", chrg_pmp_en, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_cs_n", eep_cs_n, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("arst_short_pump_seen", pump_err, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);
      rd_op("rd1_after_rst", 2'd1, 14'h2A5C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
